otp_pad_gen: RTL and testbench

- Upstream pad source for the XOR encrypt stage. Generates a stream of one-time pad bytes from a 16-bit seed using a Galois LFSR.
- Delivers one byte per valid/ready handshake.
- Enforces one-time use: after MAX_USES bytes it stops and demands a fresh seed, so no pad byte from a seed is issued past the budget.

---
 rtl/otp_pkg.sv | 17 +
 rtl/otp_pad_gen_if.sv | 28 ++
 rtl/otp_lfsr_step.sv | 24 ++
 rtl/otp_pad_gen.sv | 119 +++++++++++
 tb/tb_otp_pad_gen.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/otp_pkg.sv
// Shared definitions for the one-time pad generator.
// Holds the default pad width, LFSR width and Galois feedback mask,
// plus the controller state encoding.
package otp_pkg;

  localparam int              OTP_DATA_W = 8;
  localparam int              OTP_LFSR_W = 16;
  localparam logic [15:0]     OTP_TAPS   = 16'hB400;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILL      = 2'd1,
    RUN       = 2'd2,
    EXHAUSTED = 2'd3
  } otp_state_t;

endpackage

// File: rtl/otp_pad_gen_if.sv
// Seed and pad handshake bundle for otp_pad_gen.
// slave  : the generator side (takes seeds, offers pad bytes)
// master : the side that supplies seeds and consumes pad bytes
interface otp_pad_gen_if #(
  parameter int DATA_W = 8,
  parameter int LFSR_W = 16,
  parameter int UW     = 9
);
  logic              seed_valid;
  logic [LFSR_W-1:0] seed;
  logic              seed_ready;
  logic              seed_err;
  logic              pad_valid;
  logic              pad_ready;
  logic [DATA_W-1:0] pad;
  logic [UW-1:0]     uses;
  logic              exhausted;

  modport slave (
    input  seed_valid, seed, pad_ready,
    output seed_ready, seed_err, pad_valid, pad, uses, exhausted
  );

  modport master (
    output seed_valid, seed, pad_ready,
    input  seed_ready, seed_err, pad_valid, pad, uses, exhausted
  );
endinterface

// File: rtl/otp_lfsr_step.sv
// Unrolled right-shifting Galois LFSR: applies STEPS steps in one
// combinational pass.
// Ports: state_in  - current LFSR state
//        state_out - state after STEPS steps
module otp_lfsr_step #(
  parameter int         W     = 16,
  parameter int         STEPS = 8,
  parameter logic [W-1:0] TAPS = '0
) (
  input  logic [W-1:0] state_in,
  output logic [W-1:0] state_out
);

  logic [W-1:0] s;

  always_comb begin
    s = state_in;
    for (int i = 0; i < STEPS; i++) begin
      s = s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    end
    state_out = s;
  end

endmodule

// File: rtl/otp_pad_gen.sv
// One-time pad byte source. Loads a nonzero 16-bit seed, then emits one
// pad byte per valid/ready handshake (DATA_W LFSR steps per byte) until
// MAX_USES bytes have gone out, after which a fresh seed is required.
// Ports: clk, reset_n (async, active low)
//        bus (slave): seed_valid/seed/seed_ready/seed_err,
//                     pad_valid/pad_ready/pad, uses, exhausted
//
// state     | meaning
// IDLE      | no seed yet; accepting seeds
// FILL      | seed loaded; computing first pad byte
// RUN       | pad byte on offer; seeds ignored
// EXHAUSTED | budget spent; accepting a fresh seed
module otp_pad_gen
  import otp_pkg::*;
#(
  parameter int                DATA_W   = OTP_DATA_W,
  parameter int                LFSR_W   = OTP_LFSR_W,
  parameter logic [LFSR_W-1:0] TAPS     = OTP_TAPS,
  parameter int                MAX_USES = 256
) (
  input  logic          clk,
  input  logic          reset_n,
  otp_pad_gen_if.slave  bus
);

  localparam int            UW        = $clog2(MAX_USES + 1);
  localparam logic [UW-1:0] LAST_USE  = UW'(MAX_USES - 1);

  otp_state_t        state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_next;
  logic [DATA_W-1:0] pad_q, pad_d;
  logic              pv_q, pv_d;
  logic [UW-1:0]     uses_q, uses_d;
  logic              exh_q, exh_d;
  logic              err_q, err_d;
  logic              seed_ready;

  otp_lfsr_step #(.W(LFSR_W), .STEPS(DATA_W), .TAPS(TAPS)) u_step (
    .state_in  (lfsr_q),
    .state_out (lfsr_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      lfsr_q  <= '0;
      pad_q   <= '0;
      pv_q    <= 1'b0;
      uses_q  <= '0;
      exh_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      pad_q   <= pad_d;
      pv_q    <= pv_d;
      uses_q  <= uses_d;
      exh_q   <= exh_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    pad_d      = pad_q;
    pv_d       = pv_q;
    uses_d     = uses_q;
    exh_d      = exh_q;
    err_d      = 1'b0;
    seed_ready = 1'b0;
    case (state_q)
      IDLE, EXHAUSTED: begin
        seed_ready = 1'b1;
        if (bus.seed_valid) begin
          if (bus.seed != '0) begin
            lfsr_d  = bus.seed;
            uses_d  = '0;
            exh_d   = 1'b0;
            state_d = FILL;
          end else begin
            // A zero seed would lock the LFSR at zero forever.
            err_d = 1'b1;
          end
        end
      end
      FILL: begin
        lfsr_d  = lfsr_next;
        pad_d   = lfsr_next[DATA_W-1:0];
        pv_d    = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (pv_q && bus.pad_ready) begin
          uses_d = uses_q + 1'b1;
          if (uses_q != LAST_USE) begin
            lfsr_d = lfsr_next;
            pad_d  = lfsr_next[DATA_W-1:0];
          end else begin
            // Last byte of the budget just left; nothing more from this seed.
            pv_d    = 1'b0;
            pad_d   = '0;
            exh_d   = 1'b1;
            state_d = EXHAUSTED;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.seed_ready = seed_ready;
  assign bus.seed_err   = err_q;
  assign bus.pad_valid  = pv_q;
  assign bus.pad        = pad_q;
  assign bus.uses       = uses_q;
  assign bus.exhausted  = exh_q;

endmodule

// File: tb/tb_otp_pad_gen.sv
module tb_otp_pad_gen;

  localparam int MU = 4;
  localparam int UW = $clog2(MU + 1);

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  otp_pad_gen_if #(.DATA_W(8), .LFSR_W(16), .UW(UW)) bus();

  otp_pad_gen #(.MAX_USES(MU)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Reference model: a seed's whole pad budget is precomputed as a byte list.
  logic [7:0] q[$];
  bit         m_busy, m_fill, m_valid, m_exh, m_err;
  int         m_uses;

  function automatic logic [15:0] lfsr8(input logic [15:0] s_in);
    logic [15:0] s = s_in;
    for (int i = 0; i < 8; i++) begin
      if (s % 2 == 1) s = (s / 2) ^ 16'hB400;
      else            s = s / 2;
    end
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pad_valid"},  bus.pad_valid,  m_valid);
    chk({tag, ".pad"},        bus.pad,        (m_valid && q.size() > 0) ? q[0] : 8'h00);
    chk({tag, ".uses"},       bus.uses,       m_uses);
    chk({tag, ".exhausted"},  bus.exhausted,  m_exh);
    chk({tag, ".seed_ready"}, bus.seed_ready, !m_busy);
    chk({tag, ".seed_err"},   bus.seed_err,   m_err);
  endtask

  task automatic model_reset();
    q.delete();
    m_busy = 0; m_fill = 0; m_valid = 0; m_exh = 0; m_err = 0; m_uses = 0;
  endtask

  // Advance the model on the inputs present at this edge, clock, then compare.
  task automatic cycle(input string tag);
    bit acc = !m_busy;
    m_err = acc && bus.seed_valid && (bus.seed == 16'h0);
    if (acc && bus.seed_valid && bus.seed != 16'h0) begin
      logic [15:0] s = bus.seed;
      q.delete();
      for (int i = 0; i < MU; i++) begin
        s = lfsr8(s);
        q.push_back(s[7:0]);
      end
      m_busy = 1; m_fill = 1; m_valid = 0; m_uses = 0; m_exh = 0;
    end else if (m_fill) begin
      m_fill = 0; m_valid = 1;
    end else if (m_valid && bus.pad_ready) begin
      void'(q.pop_front());
      m_uses++;
      if (m_uses == MU) begin
        m_valid = 0; m_busy = 0; m_exh = 1;
      end
    end
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  task automatic drive(input bit sv, input logic [15:0] sd, input bit pr);
    bus.seed_valid = sv;
    bus.seed       = sd;
    bus.pad_ready  = pr;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(0, 16'h0, 0);
    model_reset();
    #1;
    chk_all("reset_async");
    @(posedge clk); #1;
    chk_all("reset_hold");
    reset_n = 1'b1;
    cycle("idle");

    // Seed 1, consumer always ready: 2-edge latency, then 68, 41, ...
    drive(1, 16'h0001, 1);
    cycle("seed1_fill");
    chk("seed1_fill_novalid", bus.pad_valid, 1'b0);
    drive(0, 16'h0, 1);
    cycle("seed1_first");
    chk("seed1_pad68", bus.pad, 8'h68);
    cycle("seed1_second");
    chk("seed1_pad41", bus.pad, 8'h41);
    cycle("seed1_b3");
    cycle("seed1_b4");
    cycle("seed1_exh");
    chk("exh_uses4", bus.uses, 3'd4);
    chk("exh_flag", bus.exhausted, 1'b1);
    cycle("exh_hold");

    // Zero seed while exhausted: pulse, stay exhausted.
    drive(1, 16'h0, 0);
    cycle("exh_zero");
    chk("exh_zero_err", bus.seed_err, 1'b1);
    drive(0, 16'h0, 0);
    cycle("exh_zero_after");
    chk("exh_zero_pulse_end", bus.seed_err, 1'b0);

    // Fresh seed restarts the stream.
    drive(1, 16'h0001, 0);
    cycle("restart_fill");
    drive(0, 16'h0, 0);
    cycle("restart_first");
    chk("restart_uses0", bus.uses, 3'd0);

    // Stall for five cycles: pad holds at 68.
    for (int i = 0; i < 5; i++) cycle("stall");
    chk("stall_pad68", bus.pad, 8'h68);
    drive(0, 16'h0, 1);
    cycle("release");
    chk("release_pad41", bus.pad, 8'h41);

    // Seed in RUN ignored, then async reset mid-handshake.
    drive(1, 16'h1234, 1);
    cycle("run_seed_ignored");
    chk("run_seed_no_err", bus.seed_err, 1'b0);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk_all("mid_reset");
    drive(0, 16'h0, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Zero seed in IDLE.
    drive(1, 16'h0, 0);
    cycle("idle_zero");
    chk("idle_zero_err", bus.seed_err, 1'b1);
    drive(0, 16'h0, 0);
    cycle("idle_zero_after");

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] sd;
      sd = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(1, 65535));
      drive($urandom_range(0, 3) == 0, sd, $urandom_range(0, 1) == 1);
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
